// File: rtl/wb_cmd_initiator_pkg.sv
// wb_cmd_initiator_pkg
// Shared types and constants for the Wishbone command initiator:
//   WB_ADR_W / WB_DAT_W : Wishbone address and data widths
//   state_t             : transfer FSM states (IDLE, REQ, GAP)
//   cmd_t               : one buffered command {we, adr, dat}, 65 bits
package wb_cmd_initiator_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// wb_cmd_initiator_if
// Wishbone classic single-transfer bus bundle.
//   master modport : drives wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL;
//                    receives wb_ACK, wb_DAT_MISO
//   slave modport  : the mirror image
interface wb_cmd_initiator_if;
  import wb_cmd_initiator_pkg::*;

  logic                wb_CYC;
  logic                wb_STB;
  logic                wb_WE;
  logic [WB_ADR_W-1:0] wb_ADR;
  logic [WB_DAT_W-1:0] wb_DAT_MOSI;
  logic                wb_SEL;
  logic                wb_ACK;
  logic [WB_DAT_W-1:0] wb_DAT_MISO;

  modport master (
    output wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
    input  wb_ACK, wb_DAT_MISO
  );

  modport slave (
    input  wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
    output wb_ACK, wb_DAT_MISO
  );

endinterface

// File: rtl/wb_cmd_initiator_fifo.sv
// wb_cmd_fifo
// Synchronous FIFO holding pending commands.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push / wdata : write request and data
//   pop / rdata  : read request; rdata always shows the head entry
//   full, empty  : status flags derived from the registered count
//   count        : number of stored entries (0..DEPTH)
module wb_cmd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // A pop frees the slot at the head, so a full FIFO may still take a
  // push in the same cycle as a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator
// Wishbone classic single-transfer initiator fed from a command FIFO.
// Each command becomes one CYC/STB transfer, followed by a one-cycle GAP
// with STB low, and a one-cycle rsp_valid pulse carrying read data.
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   cmd_*               : command stream (valid/ready, we, adr, dat)
//   rsp_*               : response pulse (valid, we, dat, err)
//   busy                : work pending or in flight
//   wb                  : Wishbone master port (wb_cmd_initiator_if.master)
// Optional feature macro WB_TIMEOUT_EN: aborts a transfer after
// TIMEOUT_CYC REQ cycles without ACK and reports rsp_err = 1.
module wb_cmd_initiator
  import wb_cmd_initiator_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  output logic                rsp_valid,
  output logic                rsp_we,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic                busy,
  wb_cmd_initiator_if.master  wb
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("wb_cmd_initiator: illegal FIFO_DEPTH or TIMEOUT_CYC");
  end

  logic [1:0]          rst_sync;
  logic                rst_n;
  state_t              state;
  state_t              state_nxt;
  cmd_t                cmd_in;
  cmd_t                head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                pop;
  logic                done;
  logic                tmo;
  logic                we_q;
  logic [WB_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0] dat_q;

  // Reset asserts immediately but releases two clocks later, so the
  // whole block leaves reset on a clean edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign cmd_in    = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat};
  assign cmd_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state != IDLE) || rsp_valid;

  wb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .wdata (cmd_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef WB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       rsp_err_q;

  // Counts REQ cycles without ACK; the cycle in which the count would
  // reach TIMEOUT_CYC is the last REQ cycle.
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (pop)                             tmo_cnt <= '0;
      else if (state == REQ && !wb.wb_ACK) tmo_cnt <= tmo_cnt + 1'b1;
      if (done) rsp_err_q <= tmo;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = REQ;
      REQ:     if (done)        state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ACK is only meaningful in REQ; it takes priority over a timeout
  // landing in the same cycle.
  always_comb begin
    pop  = 1'b0;
    done = 1'b0;
    tmo  = 1'b0;
    case (state)
      IDLE: pop = !fifo_empty;
      REQ: begin
        if (wb.wb_ACK) begin
          done = 1'b1;
`ifdef WB_TIMEOUT_EN
        end else if (tmo_hit) begin
          done = 1'b1;
          tmo  = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Bus strobes decode straight from the state register so that an
  // asynchronous reset drops them in the same cycle.
  assign wb.wb_CYC      = (state == REQ);
  assign wb.wb_STB      = (state == REQ);
  assign wb.wb_WE       = we_q;
  assign wb.wb_ADR      = adr_q;
  assign wb.wb_DAT_MOSI = dat_q;
  assign wb.wb_SEL      = 1'b1;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      if (pop) begin
        we_q  <= head.we;
        adr_q <= head.adr;
        dat_q <= head.dat;
      end
      rsp_valid <= done;
      if (done) begin
        rsp_we  <= we_q;
        rsp_dat <= (we_q || tmo) ? '0 : wb.wb_DAT_MISO;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator
// Self-checking bench for wb_cmd_initiator: a table of single transfers
// against a registered-ACK slave model, plus hand-written sequences for
// back-to-back commands, a slow slave, timeout (WB_TIMEOUT_EN builds)
// and reset in the middle of a transfer.
module tb_wb_cmd_initiator;
  import wb_cmd_initiator_pkg::*;

  localparam int DEPTH = 4;
`ifdef WB_TIMEOUT_EN
  localparam int TMO      = 8;
  localparam int LONG_DLY = 5;
`else
  localparam int TMO      = 255;
  localparam int LONG_DLY = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_we;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  wb_cmd_initiator_if bus ();

  wb_cmd_initiator #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .rsp_valid (rsp_valid),
    .rsp_we    (rsp_we),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  // Slave model: ACK rises after ack_delay strobed cycles and lasts one
  // cycle. Read data is either a fixed value or a hash of the address.
  logic        ack_en;
  int          ack_delay;
  int          wcnt;
  logic        use_hash;
  logic [31:0] miso_val;

  assign bus.wb_DAT_MISO = use_hash ? (bus.wb_ADR ^ 32'hC0DE_0000) : miso_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_ACK <= 1'b0;
      wcnt       <= 0;
    end else if (bus.wb_CYC && bus.wb_STB && !bus.wb_ACK && ack_en) begin
      if (wcnt == ack_delay - 1) begin
        bus.wb_ACK <= 1'b1;
        wcnt       <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      bus.wb_ACK <= 1'b0;
      if (!(bus.wb_CYC && bus.wb_STB)) wcnt <= 0;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] miso;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [4];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pushes one command into an idle block and follows it to its response.
  task automatic apply_stimulus(input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [31:0] miso,
                                input logic [31:0] exp_dat, input string tag);
    int   lat;
    int   req_cyc;
    logic stable;
    logic seen;
    use_hash = 1'b0;
    miso_val = miso;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    @(posedge clk);
    lat = 0; req_cyc = 0; stable = 1'b1; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      if (bus.wb_STB) begin
        req_cyc++;
        if (!bus.wb_CYC || bus.wb_ADR !== adr || bus.wb_WE !== we ||
            bus.wb_DAT_MOSI !== dat) stable = 1'b0;
      end
      if (rsp_valid) seen = 1'b1;
    end
    check_output({tag, " rsp_seen"}, 32'(seen), 32'd1);
    check_output({tag, " latency"}, lat, ack_delay + 3);
    check_output({tag, " req_cycles"}, req_cyc, ack_delay + 1);
    check_output({tag, " bus_stable"}, 32'(stable), 32'd1);
    check_output({tag, " rsp_we"}, 32'(rsp_we), 32'(we));
    check_output({tag, " rsp_dat"}, rsp_dat, exp_dat);
    check_output({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    check_output({tag, " gap_stb"}, 32'(bus.wb_STB), 32'd0);
    check_output({tag, " busy_rsp"}, 32'(busy), 32'd1);
    @(negedge clk);
    check_output({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] b_adr [5];
    logic        b_we  [5];
    int          accepted;
    int          guard;
    int          idx;
    int          n;
    int          last;
    logic        ready_at;
    logic        quiet;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    ack_en = 1'b1; ack_delay = 1; use_hash = 1'b0; miso_val = '0;

    vecs[0] = '{we: 1'b1, adr: 32'h0000_0000, dat: 32'h0000_0005,
                miso: 32'hFFFF_FFFF, exp_dat: 32'h0000_0000};
    vecs[1] = '{we: 1'b0, adr: 32'h0000_0010, dat: 32'hDEAD_0000,
                miso: 32'h0123_4567, exp_dat: 32'h0123_4567};
    vecs[2] = '{we: 1'b1, adr: 32'h0000_0FF0, dat: 32'hDEAD_BEEF,
                miso: 32'h1111_1111, exp_dat: 32'h0000_0000};
    vecs[3] = '{we: 1'b0, adr: 32'h3000_0004, dat: 32'h0000_0000,
                miso: 32'hA5A5_5A5A, exp_dat: 32'hA5A5_5A5A};

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("rst busy", 32'(busy), 32'd0);
    check_output("rst cyc", 32'(bus.wb_CYC), 32'd0);
    check_output("rst stb", 32'(bus.wb_STB), 32'd0);
    check_output("rst we", 32'(bus.wb_WE), 32'd0);
    check_output("rst adr", bus.wb_ADR, 32'd0);
    check_output("rst mosi", bus.wb_DAT_MOSI, 32'd0);
    check_output("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst rsp_dat", rsp_dat, 32'd0);
    check_output("rst rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single transfers from the table
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].miso,
                     vecs[i].exp_dat, $sformatf("vec%0d", i));
    end

    // Back-to-back: stall the slave so one command sits in REQ and four
    // fill the FIFO, then release and collect all five in order.
    for (int i = 0; i < 5; i++) begin
      b_adr[i] = 32'h0000_0100 + 32'(i * 4);
      b_we[i]  = (i % 2) == 1;
    end
    ack_en = 1'b0; use_hash = 1'b1;
    accepted = 0; guard = 0;
    while (accepted < 5 && guard < 40) begin
      @(negedge clk);
      guard++;
      cmd_valid = 1'b1;
      cmd_we    = b_we[accepted];
      cmd_adr   = b_adr[accepted];
      cmd_dat   = 32'h0000_5000 + 32'(accepted);
      ready_at  = cmd_ready;
      @(posedge clk);
      if (ready_at) accepted++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("b2b push_cycles", guard, 5);
    check_output("b2b ready_full", 32'(cmd_ready), 32'd0);
    ack_en = 1'b1;
    idx = 0; n = 0; last = 0;
    while (idx < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        check_output($sformatf("b2b rsp%0d_we", idx), 32'(rsp_we), 32'(b_we[idx]));
        check_output($sformatf("b2b rsp%0d_dat", idx), rsp_dat,
                     b_we[idx] ? 32'd0 : (b_adr[idx] ^ 32'hC0DE_0000));
        if (idx > 0) check_output($sformatf("b2b rsp%0d_space_ok", idx),
                                  32'(n - last >= 3), 32'd1);
        last = n;
        idx++;
      end
    end
    check_output("b2b rsp_count", idx, 5);
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_output("b2b busy_clear", 32'(busy), 32'd0);

    // Slow slave
    ack_delay = LONG_DLY;
    apply_stimulus(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h9999_9999, 32'd0, "slow");
    ack_delay = 1;

`ifdef WB_TIMEOUT_EN
    // Timeout with no ACK, then a normal command
    ack_en = 1'b0; use_hash = 1'b0; miso_val = 32'h5555_AAAA;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_0030; cmd_dat = '0;
    @(posedge clk);
    n = 0; guard = 0;
    while (!rsp_valid && guard < 60) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      guard++;
      if (bus.wb_STB) n++;
    end
    check_output("tmo stb_cycles", n, TMO);
    check_output("tmo rsp_valid", 32'(rsp_valid), 32'd1);
    check_output("tmo rsp_err", 32'(rsp_err), 32'd1);
    check_output("tmo rsp_dat", rsp_dat, 32'd0);
    ack_en = 1'b1;
    apply_stimulus(1'b0, 32'h0000_0034, 32'd0, 32'h1357_2468, 32'h1357_2468, "post_tmo");
`endif

    // Reset during REQ with a second command queued
    ack_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0000_0050; cmd_dat = 32'h1;
    @(negedge clk);
    cmd_adr = 32'h0000_0054; cmd_dat = 32'h2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("mid stb_before", 32'(bus.wb_STB), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid cyc_async", 32'(bus.wb_CYC), 32'd0);
    check_output("mid stb_async", 32'(bus.wb_STB), 32'd0);
    quiet = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) quiet = 1'b0;
    end
    check_output("mid no_rsp", 32'(quiet), 32'd1);
    check_output("mid busy", 32'(busy), 32'd0);
    check_output("mid cmd_ready", 32'(cmd_ready), 32'd1);
    ack_en = 1'b1;
    apply_stimulus(1'b0, 32'h0000_0040, 32'd0, 32'h7777_0001, 32'h7777_0001, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
